mux_scan_nto1: RTL and testbench
================================

# mux_scan_nto1

Parametrised, registered N-to-1 channel multiplexer with a built-in channel sequencer and a valid/ready output stage. It replaces the flat combinational 32:1 select used in the MUX-based counter datapath. A single start command sweeps a run of channels (up or down, with wrap-around), one channel or a repeating sweep, and presents each sample with its channel index to a downstream consumer under backpressure.

## Interface
- `CH_COUNT`, default 32: number of channels, 2..256, need not be a power of two.
- `DATA_W`, default 1: bits per channel.
- `SEL_W`, default 5: channel index width; must be ≥ clog2(CH_COUNT).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inp` in CH_COUNT*DATA_W: channel data; channel k occupies bits [k*DATA_W +: DATA_W]; sampled live at each load.
- `sel` in SEL_W: start channel, sampled with `start`.
- `len` in SEL_W+1: number of samples; 0 means CH_COUNT (one full sweep).
- `mode` in 2: bit0 sets direction (0 up, 1 down); bit1 selects continuous mode (ignore `len`, run until `stop`).
- `start` in 1: command strobe; honoured only when `busy`=0.
- `stop` in 1: ends a continuous run; ignored in counted mode.
- `out_data` out DATA_W: sampled channel data.
- `out_ch` out SEL_W: index of the channel in `out_data`.
- `out_valid` out 1: output register holds an unconsumed sample.
- `out_ready` in 1: consumer accepts; a beat transfers on an edge with `out_valid`&&`out_ready`.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- **IDLE:**
  - `start`=1 with `sel` < CH_COUNT: latch `mode` and the remaining count (`len`, or CH_COUNT if `len`=0). Load sample `inp[sel]` and `out_ch`=`sel` on the same edge. Advance the pointer and decrement the remaining count.
  - Next state is DRAIN if the remaining count reaches 0 in counted mode, otherwise RUN. `busy` is 1 from that edge.
  - `start`=1 with `sel` ≥ CH_COUNT: no state change; `err`=1 for the next cycle.
- **RUN:**
  - A load happens on each edge where `out_valid`=0 or `out_ready`=1. A load captures the pointer channel, then advances the pointer.
  - Up direction: the pointer wraps from CH_COUNT-1 to 0. Down direction: it wraps from 0 to CH_COUNT-1.
  - Counted mode: after the final load, go to DRAIN.
  - Continuous mode: `stop`=1 on any edge suppresses that edge's load and goes to DRAIN. The count is unused.
- **DRAIN:**
  - No loads.
  - If `out_valid`=0, or on the edge where the held beat transfers, go to IDLE, set `done`=1 for one cycle and drop `busy`.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_ch` hold stable and the pointer does not advance. No channel is skipped or duplicated.
- The following are ignored while `busy`=1: `start`, `sel`, `len` and `mode`. `err` is not raised in that case.
- `len` > CH_COUNT is legal; the sweep keeps wrapping, so some channels are sampled more than once.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `busy`=0, `done`=0, `err`=0. The FSM enters IDLE and the pointer and count are cleared.
- Reset mid-command aborts immediately. The pending beat is discarded and no `done` is issued.
- Latency: `out_valid` rises in the cycle after the `start` edge.
- Throughput: one beat per cycle while `out_ready`=1.
- Counted run of L samples with `out_ready` held at 1: beats appear on cycles 1..L after start, and `done` is high on cycle L+1.
- `busy` and `done` change on the same edge (`busy` falls as `done` rises).
- The earliest next `start` is sampled on the `done` cycle, so back-to-back commands are possible.

## Test plan
- **Reset:** assert `rst` mid-run (`busy`=1, `out_valid`=1) → all outputs are 0 asynchronously; no `done` after release.
- **Up sweep with wrap:** CH_COUNT=32, DATA_W=1, `inp`=32'hA5A5_0F0F, `sel`=30, `len`=4, `mode`=00, `out_ready`=1 → (`out_ch`,`out_data`) = (30,0),(31,1),(0,1),(1,1) on cycles 1-4; `done` on cycle 5.
- **Down sweep with wrap:** same `inp`, `sel`=1, `len`=3, `mode`=01 → channels 1,0,31 with data 1,1,1; `done` on cycle 4.
- **Backpressure:** `len`=4 up from 0, `out_ready`=0 for cycles 2-4 → `out_ch`=1 held stable for 3 cycles; sequence 0,1,2,3 intact; `done` 3 cycles later than the no-stall case.
- **Full and continuous:**
  - `len`=0 → 32 beats covering channels 0..31 once.
  - `mode`=10 with `stop` pulsed after 40 beats → wrap observed at 31→0, no loads after `stop`, `done` follows the last handshake.
- **Rejects:** instance with CH_COUNT=20, `sel`=25, `start` → `err` pulse, `busy` stays 0. `start` during a run → ignored, run unaffected.

Source files
------------

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 channel multiplexer with a built-in up/down channel sequencer
// and a valid/ready output stage; sweeps counted or continuous runs of channels.
module mux_scan_nto1 #(
    parameter int unsigned CH_COUNT = 32,
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned SEL_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_COUNT*DATA_W-1:0]   inp,
    input  logic [SEL_W-1:0]             sel,
    input  logic [SEL_W:0]               len,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic                         stop,
    output logic [DATA_W-1:0]            out_data,
    output logic [SEL_W-1:0]             out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int unsigned     CW      = SEL_W + 1;
    localparam logic [CW-1:0]   CH_N    = CW'(CH_COUNT);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CH_COUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              dir, dir_n;
    logic              cont, cont_n;
    logic [DATA_W-1:0] data_n, ld_data;
    logic [SEL_W-1:0]  ch_n, ld_idx, ch_nxt;
    logic              valid_n, busy_n, done_n, err_n;
    logic              load, xfer, sel_ok, dir_sel;

    // In IDLE the load comes from the command itself, afterwards from the pointer
    assign ld_idx  = (state == IDLE) ? sel : ptr;
    assign dir_sel = (state == IDLE) ? mode[0] : dir;
    assign sel_ok  = ({1'b0, sel} < CH_N);
    assign xfer    = out_valid && out_ready;

    // Successor channel with wrap in both directions (CH_COUNT need not be 2^n)
    always_comb begin
        ch_nxt = '0;
        if (dir_sel) begin
            ch_nxt = (ld_idx == '0) ? CH_LAST : ld_idx - SEL_W'(1);
        end else begin
            ch_nxt = (ld_idx == CH_LAST) ? '0 : ld_idx + SEL_W'(1);
        end
    end

    // Channel data select
    always_comb begin
        ld_data = '0;
        for (int unsigned k = 0; k < CH_COUNT; k++) begin
            if (ld_idx == SEL_W'(k)) begin
                ld_data = inp[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        dir_n   = dir;
        cont_n  = cont;
        data_n  = out_data;
        ch_n    = out_ch;
        valid_n = out_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        load    = 1'b0;

        if (xfer) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        load    = 1'b1;
                        dir_n   = mode[0];
                        cont_n  = mode[1];
                        cnt_n   = ((len == '0) ? CH_N : len) - CW'(1);
                        busy_n  = 1'b1;
                        state_n = (!mode[1] && cnt_n == '0) ? DRAIN : RUN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cont && stop) begin
                    state_n = DRAIN;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    if (!cont) begin
                        cnt_n = cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state_n = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            data_n  = ld_data;
            ch_n    = ld_idx;
            valid_n = 1'b1;
            ptr_n   = ch_nxt;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            cont      <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            dir       <= dir_n;
            cont      <= cont_n;
            out_data  <= data_n;
            out_ch    <= ch_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Randomized self-checking bench for mux_scan_nto1: expected beats come from
// modular channel arithmetic, checked at each handshake under random backpressure.
module tb_mux_scan_nto1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inp;
    logic [4:0]  sel;
    logic [5:0]  len;
    logic [1:0]  mode;
    logic        start, stop, out_ready;
    logic [0:0]  out_data;
    logic [4:0]  out_ch;
    logic        out_valid, busy, done, err;

    logic [19:0] inp20;
    logic [4:0]  sel20;
    logic [5:0]  len20;
    logic [1:0]  mode20;
    logic        start20, stop20, ready20;
    logic [0:0]  out_data20;
    logic [4:0]  out_ch20;
    logic        valid20, busy20, done20, err20;

    int          n_chk = 0;
    int          n_pass = 0;
    int          stall_pct = 0;
    logic [63:0] stall_mask = '0;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.CH_COUNT(32), .DATA_W(1), .SEL_W(5)) dut (
        .clk(clk), .rst(rst), .inp(inp), .sel(sel), .len(len), .mode(mode),
        .start(start), .stop(stop), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    mux_scan_nto1 #(.CH_COUNT(20), .DATA_W(1), .SEL_W(5)) dut20 (
        .clk(clk), .rst(rst), .inp(inp20), .sel(sel20), .len(len20), .mode(mode20),
        .start(start20), .stop(stop20), .out_data(out_data20), .out_ch(out_ch20),
        .out_valid(valid20), .out_ready(ready20), .busy(busy20), .done(done20), .err(err20)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Issue one command on the 32-channel instance and follow it to done
    task automatic run_cmd(input int s, input int l, input logic [1:0] m,
                           input int stop_after, input bit poke, input int exp_done);
        int total, got, done_due, exp_ch;
        bit stopped, prev_stall, fin;
        logic [4:0] pch;
        logic       pd;
        total    = m[1] ? (1 << 30) : ((l == 0) ? 32 : l);
        got      = 0;
        done_due = -1;
        stopped  = 0;
        prev_stall = 0;
        fin      = 0;
        pch      = '0;
        pd       = 1'b0;
        sel = 5'(s); len = 6'(l); mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("latency_valid", 32'(out_valid), 1);
        for (int cyc = 1; cyc < 4000 && !fin; cyc++) begin
            stop = 1'b0;
            if (cyc == done_due) begin
                chk("done", 32'(done), 1);
                chk("busy_end", 32'(busy), 0);
                chk("valid_end", 32'(out_valid), 0);
                chk("beat_total", got, total);
                if (exp_done > 0) chk("done_cycle", cyc, exp_done);
                fin = 1;
            end else begin
                chk("done_early", 32'(done), 0);
                chk("busy_run", 32'(busy), 1);
                if (poke && cyc == 3) chk("err_while_busy", 32'(err), 0);
                if (prev_stall) begin
                    chk("hold_ch", 32'(out_ch), 32'(pch));
                    chk("hold_data", 32'(out_data), 32'(pd));
                end
                out_ready = !(cyc < 64 && stall_mask[cyc]) && ($urandom_range(0, 99) >= stall_pct);
                start = poke && (cyc == 2);
                if (start) begin
                    sel = 5'(s + 7); len = 6'd1; mode = ~m;
                end
                if (!m[1]) stop = ($urandom_range(0, 3) == 0);
                if (m[1] && !stopped && out_valid && got == stop_after - 1) begin
                    stop = 1'b1; stopped = 1; total = stop_after;
                end
                prev_stall = out_valid && !out_ready;
                pch = out_ch;
                pd  = out_data;
                if (out_valid && out_ready) begin
                    if (got >= total) chk("extra_beat", got, total);
                    exp_ch = m[0] ? (s - (got % 32) + 32) % 32 : (s + got) % 32;
                    chk("beat_ch", 32'(out_ch), exp_ch);
                    chk("beat_data", 32'(out_data), 32'(inp[exp_ch]));
                    got++;
                    if (got == total) done_due = cyc + ((m[1] && stop) ? 2 : 1);
                end
                @(negedge clk);
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    // Counted command on the 20-channel instance with ready held high
    task automatic run20(input int s, input int l, input bit down);
        int exp_ch;
        sel20 = 5'(s); len20 = 6'(l); mode20 = {1'b0, down}; start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
        for (int i = 0; i < l; i++) begin
            exp_ch = down ? (s - i + 20) % 20 : (s + i) % 20;
            chk("ch20", 32'(out_ch20), exp_ch);
            chk("data20", 32'(out_data20), 32'(inp20[exp_ch]));
            @(negedge clk);
        end
        chk("done20", 32'(done20), 1);
        chk("busy20_end", 32'(busy20), 0);
    endtask

    initial begin
        rst = 1'b1;
        inp = '0; sel = '0; len = '0; mode = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        inp20 = '0; sel20 = '0; len20 = '0; mode20 = '0; start20 = 1'b0; stop20 = 1'b0; ready20 = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_data", 32'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);

        inp = 32'hA5A5_0F0F;
        run_cmd(30, 4, 2'b00, 0, 0, 5);
        run_cmd(1, 3, 2'b01, 0, 0, 4);
        stall_mask = 64'h1C;
        run_cmd(0, 4, 2'b00, 0, 0, 8);
        stall_mask = '0;
        run_cmd(0, 0, 2'b00, 0, 0, 33);
        run_cmd(0, 0, 2'b10, 40, 0, 42);
        run_cmd(10, 20, 2'b01, 0, 1, 21);

        // Rejected start and non-power-of-two wrap
        sel20 = 5'd25; start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
        chk("err20", 32'(err20), 1);
        chk("busy20_rej", 32'(busy20), 0);
        chk("valid20_rej", 32'(valid20), 0);
        @(negedge clk);
        chk("err20_pulse", 32'(err20), 0);
        inp20 = 20'h8_0002;
        run20(19, 3, 1'b0);
        run20(0, 2, 1'b1);

        for (int t = 0; t < 16; t++) begin
            int s, l, sa;
            logic [1:0] m;
            inp = $urandom;
            s = int'($urandom_range(0, 31));
            l = int'($urandom_range(0, 63));
            m = 2'($urandom_range(0, 3));
            sa = m[1] ? int'($urandom_range(1, 70)) : 0;
            stall_pct = int'($urandom_range(0, 60));
            run_cmd(s, l, m, sa, t[0], 0);
        end
        stall_pct = 0;
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a stalled run
        inp = 32'h0000_0008;
        sel = 5'd3; len = '0; mode = 2'b00; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_ch", 32'(out_ch), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        inp = 32'h1234_5678;
        run_cmd(7, 5, 2'b01, 0, 0, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
